// File: rtl/alu_pkg.sv
// Shared types and field helpers for the ALU issue/write-back sequencer.
package alu_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

    function automatic logic [6:0] opcode_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [4:0] rs1_of(input logic [31:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32x32 register file: two operand read ports, one debug read port, one write port.
// x0 reads as zero and is never written; contents clear on asynchronous reset.
module rv_regfile #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    input  logic [4:0]      dbg_addr_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    output logic [XLEN-1:0] dbg_data_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o      = (ra1_i == 5'd0) ? '0 : regs_q[ra1_i];
    assign rd2_o      = (ra2_i == 5'd0) ? '0 : regs_q[ra2_i];
    assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_wb.sv
// Operand-side sequencer for a combinational RV32 ALU: IDLE -> READ -> EXEC -> WB.
// Optional retire counter port enabled by defining ALU_ISSUE_RETIRE_CNT_EN.
module alu_issue_wb
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    output logic [31:0]     alu_code,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    input  logic [XLEN-1:0] alu_rd,
    output logic            wb_valid,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal,
`ifdef ALU_ISSUE_RETIRE_CNT_EN
    output logic [31:0]     retire_cnt,
`endif
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    state_e          state_q;
    logic [31:0]     instr_q;
    logic [31:0]     alu_code_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic [XLEN-1:0] result_q;
    logic            instr_ready_q;
    logic            wb_valid_q;
    logic            illegal_q;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;
    logic [6:0]      in_opcode;

    assign in_opcode = opcode_of(instr);

    rv_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .ra1_i      (rs1_of(instr_q)),
        .ra2_i      (rs2_of(instr_q)),
        .dbg_addr_i (dbg_addr),
        .rd1_o      (rf_rd1),
        .rd2_o      (rf_rd2),
        .dbg_data_o (dbg_data),
        .we_i       (wb_valid_q),
        .wa_i       (rd_of(instr_q)),
        .wd_i       (result_q)
    );

    // ALU-facing registers are loaded only on READ -> EXEC so they hold between instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            alu_code_q    <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            result_q      <= '0;
            instr_ready_q <= 1'b1;
            wb_valid_q    <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    illegal_q <= 1'b0;
                    if (instr_valid && instr_ready_q) begin
                        instr_q <= instr;
                        if ((in_opcode == OP_R) || (in_opcode == OP_I)) begin
                            state_q       <= READ;
                            instr_ready_q <= 1'b0;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    alu_code_q <= instr_q;
                    op1_q      <= rf_rd1;
                    op2_q      <= (opcode_of(instr_q) == OP_R) ? rf_rd2 : '0;
                    state_q    <= EXEC;
                end
                EXEC: begin
                    result_q   <= alu_rd;
                    wb_valid_q <= 1'b1;
                    state_q    <= WB;
                end
                WB: begin
                    wb_valid_q    <= 1'b0;
                    instr_ready_q <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else if (wb_valid_q) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;
`endif

    assign instr_ready = instr_ready_q;
    assign alu_code    = alu_code_q;
    assign alu_rs1     = op1_q;
    assign alu_rs2     = op2_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = rd_of(instr_q);
    assign wb_data     = result_q;
    assign illegal     = illegal_q;

endmodule
